// File: rtl/lif_membrane_trace.sv
// Leaky integrate-and-fire membrane with a circular trace of per-frame samples.
// The membrane updates once per frame tick (VSync falling edge). The trace is
// read back oldest-first through a registered random-access port that the
// display stage indexes by screen column.
//
// state      | meaning
// -----------+------------------------------------------------------------
// CLEAR      | zero the trace buffer, one address per cycle
// IDLE       | wait for a frame tick; input spikes accumulate in pending
// LEAK       | V -= V >> LEAK_SHIFT
// INTEGRATE  | add n spikes (or burn one refractory frame and drop them)
// FIRE_CHECK | fire on threshold, choose the sample to record
// WRITE      | store sample at wr_ptr and advance the pointer
module lif_membrane_trace #(
  parameter int MEM_WIDTH         = 8,
  parameter int TRACE_DEPTH       = 64,
  parameter int LEAK_SHIFT        = 3,
  parameter int SPIKE_WEIGHT      = 48,
  parameter int THRESHOLD         = 200,
  parameter int REFRACTORY_FRAMES = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Action_Potential,
  input  logic                           i_VSync,
  input  logic [$clog2(TRACE_DEPTH)-1:0] i_Rd_Addr,
  output logic [MEM_WIDTH-1:0]           o_Rd_Data,
  output logic [MEM_WIDTH-1:0]           o_Membrane,
  output logic                           o_Fire,
  output logic                           o_Refractory,
  output logic                           o_Ready
);

  localparam int ADDR_W = $clog2(TRACE_DEPTH);
  // +2 keeps the counter at least one bit wide and able to hold the reload value
  localparam int REFR_W = $clog2(REFRACTORY_FRAMES + 2);

  typedef logic [MEM_WIDTH-1:0]   mem_t;
  typedef logic [MEM_WIDTH+1:0]   wide_t;
  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [REFR_W-1:0]      refr_t;

  localparam mem_t  V_MAX      = '1;
  localparam wide_t V_MAX_WIDE = wide_t'(V_MAX);
  localparam mem_t  THRESH     = mem_t'(THRESHOLD);
  localparam wide_t WEIGHT     = wide_t'(SPIKE_WEIGHT);
  localparam refr_t REFR_LOAD  = refr_t'(REFRACTORY_FRAMES);
  localparam addr_t LAST_ADDR  = addr_t'(TRACE_DEPTH - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LEAK,
    S_INTEGRATE,
    S_FIRE_CHECK,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  mem_t        v_q, v_d;
  mem_t        sample_q, sample_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  n_q, n_d;
  refr_t       refr_q, refr_d;
  addr_t       wr_ptr_q, wr_ptr_d;
  logic        ap_q, vsync_q;
  mem_t        rd_data_q, rd_data_d;

  mem_t        trace_mem [TRACE_DEPTH];
  logic        mem_we;
  mem_t        mem_wdata;
  addr_t       rd_idx;

  logic        spike_rise;
  logic        frame_tick;
  logic        fire;
  wide_t       weight_sum;
  wide_t       integ_sum;

  assign spike_rise = i_Action_Potential & ~ap_q;
  assign frame_tick = vsync_q & ~i_VSync;

  // n is at most 3, so the product and V together stay within MEM_WIDTH+2 bits
  assign weight_sum = wide_t'(n_q) * WEIGHT;
  assign integ_sum  = wide_t'(v_q) + weight_sum;

  // Pending spike counter; a spike on the tick cycle belongs to the next frame
  always_comb begin
    pending_d = pending_q;
    if (state_q == S_IDLE && frame_tick) begin
      pending_d = {1'b0, spike_rise};
    end else if (spike_rise && pending_q != 2'd3) begin
      pending_d = pending_q + 2'd1;
    end
  end

  // Next-state and datapath for the per-frame membrane update
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    n_d       = n_q;
    refr_d    = refr_q;
    wr_ptr_d  = wr_ptr_q;
    sample_d  = sample_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    fire      = 1'b0;

    case (state_q)
      S_CLEAR: begin
        // wr_ptr doubles as the clear address and wraps back to 0 when done
        mem_we    = 1'b1;
        mem_wdata = '0;
        wr_ptr_d  = wr_ptr_q + addr_t'(1);
        if (wr_ptr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (frame_tick) begin
          n_d     = pending_q;
          state_d = S_LEAK;
        end
      end

      S_LEAK: begin
        v_d     = v_q - (v_q >> LEAK_SHIFT);
        state_d = S_INTEGRATE;
      end

      S_INTEGRATE: begin
        if (refr_q != '0) begin
          refr_d = refr_q - refr_t'(1);
        end else if (integ_sum > V_MAX_WIDE) begin
          v_d = V_MAX;
        end else begin
          v_d = integ_sum[MEM_WIDTH-1:0];
        end
        state_d = S_FIRE_CHECK;
      end

      S_FIRE_CHECK: begin
        if (refr_q == '0 && v_q >= THRESH) begin
          fire     = 1'b1;
          sample_d = V_MAX;
          v_d      = '0;
          refr_d   = REFR_LOAD;
        end else begin
          sample_d = v_q;
        end
        state_d = S_WRITE;
      end

      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = sample_q;
        wr_ptr_d  = wr_ptr_q + addr_t'(1);
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Read index is relative to the write pointer so address 0 is the oldest sample
  always_comb begin
    rd_idx    = wr_ptr_q + i_Rd_Addr;
    rd_data_d = trace_mem[rd_idx];
  end

  // Control and datapath registers
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_CLEAR;
      v_q       <= '0;
      sample_q  <= '0;
      pending_q <= '0;
      n_q       <= '0;
      refr_q    <= '0;
      wr_ptr_q  <= '0;
      ap_q      <= 1'b0;
      vsync_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      sample_q  <= sample_d;
      pending_q <= pending_d;
      n_q       <= n_d;
      refr_q    <= refr_d;
      wr_ptr_q  <= wr_ptr_d;
      ap_q      <= i_Action_Potential;
      vsync_q   <= i_VSync;
      rd_data_q <= rd_data_d;
    end
  end

  // Trace storage; no reset, the CLEAR pass zeroes it instead
  always_ff @(posedge i_Clk) begin
    if (mem_we) begin
      trace_mem[wr_ptr_q] <= mem_wdata;
    end
  end

  assign o_Rd_Data    = rd_data_q;
  assign o_Membrane   = v_q;
  assign o_Fire       = fire;
  assign o_Refractory = (refr_q != '0);
  assign o_Ready      = (state_q != S_CLEAR);

endmodule

// File: tb/tb_lif_membrane_trace.sv
// Directed bench for lif_membrane_trace with hand-computed membrane values.
module tb_lif_membrane_trace;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ap = 1'b0;
  logic       vsync = 1'b0;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [7:0] membrane;
  logic       fire;
  logic       refractory;
  logic       ready;

  int n_checks = 0;
  int n_errors = 0;

  lif_membrane_trace dut (
    .i_Clk              (clk),
    .i_Rst              (rst),
    .i_Action_Potential (ap),
    .i_VSync            (vsync),
    .i_Rd_Addr          (rd_addr),
    .o_Rd_Data          (rd_data),
    .o_Membrane         (membrane),
    .o_Fire             (fire),
    .o_Refractory       (refractory),
    .o_Ready            (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int lows);
    lows = 0;
    while (!ready && lows < 200) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input bit check_len);
    int lows;
    @(negedge clk);
    rst = 1'b1; ap = 1'b0; vsync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(lows);
    if (check_len) check_val("ready_delay", lows, 64);
  endtask

  task automatic read_trace(input int addr, output int data);
    @(negedge clk);
    rd_addr = addr[5:0];
    @(negedge clk);
    data = rd_data;
  endtask

  task automatic press();
    @(negedge clk);
    ap = 1'b1;
    @(negedge clk);
    ap = 1'b0;
  endtask

  // One frame: VSync high then low; watches o_Fire through the update
  task automatic frame(input bit press_on_tick, output int fire_cnt, output int fire_idx);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    if (press_on_tick) ap = 1'b1;
    fire_cnt = 0;
    fire_idx = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fire) begin
        fire_cnt++;
        fire_idx = i;
      end
      ap = 1'b0;
    end
  endtask

  initial begin
    int d, fc, fi, fires, lows;
    int exp_v3 [5] = '{48, 90, 127, 160, 188};

    // Test 1: reset and clear
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready(lows);
    check_val("t1_ready_delay", lows, 64);
    check_val("t1_membrane", membrane, 0);
    check_val("t1_refractory", refractory, 0);
    for (int a = 0; a < 64; a++) begin
      read_trace(a, d);
      check_val($sformatf("t1_clear_addr%0d", a), d, 0);
    end

    // Test 2: single press, three frames
    fires = 0;
    press();
    frame(1'b0, fc, fi); fires += fc;
    check_val("t2_v1", membrane, 48);
    frame(1'b0, fc, fi); fires += fc;
    check_val("t2_v2", membrane, 42);
    frame(1'b0, fc, fi); fires += fc;
    check_val("t2_v3", membrane, 37);
    check_val("t2_no_fire", fires, 0);
    read_trace(61, d); check_val("t2_rd61", d, 48);
    read_trace(62, d); check_val("t2_rd62", d, 42);
    read_trace(63, d); check_val("t2_rd63", d, 37);

    // Test 3: one press per frame until fire
    do_reset(1'b1);
    for (int f = 0; f < 5; f++) begin
      press();
      frame(1'b0, fc, fi);
      check_val($sformatf("t3_v%0d", f + 1), membrane, exp_v3[f]);
      check_val($sformatf("t3_nofire%0d", f + 1), fc, 0);
    end
    press();
    frame(1'b0, fc, fi);
    check_val("t3_fire_count", fc, 1);
    check_val("t3_fire_cycle", fi, 2);
    check_val("t3_v_after_fire", membrane, 0);
    check_val("t3_refractory", refractory, 1);
    read_trace(63, d); check_val("t3_rd63", d, 255);

    // Test 4: refractory frames discard input
    for (int f = 1; f <= 4; f++) begin
      press();
      frame(1'b0, fc, fi);
      check_val($sformatf("t4_v%0d", f), membrane, 0);
      check_val($sformatf("t4_refr%0d", f), refractory, (f < 4) ? 1 : 0);
    end
    press();
    frame(1'b0, fc, fi);
    check_val("t4_v5", membrane, 48);
    check_val("t4_refr5", refractory, 0);

    // Test 5: pending saturation and press on the tick cycle
    do_reset(1'b0);
    repeat (5) press();
    frame(1'b0, fc, fi);
    check_val("t5_sat", membrane, 144);
    frame(1'b1, fc, fi);
    check_val("t5_tick_press_deferred", membrane, 126);
    frame(1'b0, fc, fi);
    check_val("t5_tick_press_counted", membrane, 159);
    check_val("t5_no_fire", fc, 0);

    // Test 6: wrap, then reset in the middle of an update
    do_reset(1'b0);
    for (int f = 1; f <= 70; f++) begin
      if (f == 7) press();
      frame(1'b0, fc, fi);
    end
    check_val("t6_v_final", membrane, 7);
    read_trace(1, d); check_val("t6_rd1", d, 42);
    read_trace(0, d); check_val("t6_rd0", d, 48);
    @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_rst_membrane", membrane, 0);
    check_val("t6_rst_rd_data", rd_data, 0);
    check_val("t6_rst_ready", ready, 0);
    check_val("t6_rst_fire", fire, 0);
    check_val("t6_rst_refr", refractory, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(lows);
    check_val("t6_ready_delay", lows, 64);
    read_trace(0, d); check_val("t6_cleared_rd0", d, 0);
    read_trace(63, d); check_val("t6_cleared_rd63", d, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
